// File: rtl/grex_pkt_pkg.sv
// Shared definitions for the 64-bit packet stream: rx state encodings, default sizes,
// sample field positions inside a data word and the payload buffer entry layout.
package grex_pkt_pkg;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_PAYLOAD = 2'd1,
        RX_DISCARD = 2'd2
    } rx_state_e;

    localparam int WORDS_PER_PKT_DEF = 1024;
    localparam int FIFO_DEPTH_DEF    = 1024;

    // Each data word carries two {ch_a, ch_b} pairs, older pair in the upper half.
    localparam int A0_MSB = 63;
    localparam int A0_LSB = 48;
    localparam int B0_MSB = 47;
    localparam int B0_LSB = 32;
    localparam int A1_MSB = 31;
    localparam int A1_LSB = 16;
    localparam int B1_MSB = 15;
    localparam int B1_LSB = 0;

    localparam int FIRST_BIT = 64;
    localparam int SYNC_BIT  = 65;
    localparam int ENTRY_W   = 66;

    // Delta is clipped to 32 bits first, then added with saturation.
    function automatic logic [31:0] drop_add(input logic [31:0] cnt, input logic [63:0] delta);
        logic [31:0] clip;
        logic [32:0] sum;
        clip = (delta[63:32] != 32'd0) ? 32'hFFFF_FFFF : delta[31:0];
        sum  = {1'b0, cnt} + {1'b0, clip};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/depack_fifo.sv
// Synchronous payload FIFO with registered read data (one cycle after rd_en).
// Writes to a full FIFO are ignored; ce=0 freezes pointers, memory and read data.
module depack_fifo
    import grex_pkt_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr = ce && wr_en && !full;
    assign do_rd = ce && rd_en && !empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/depacketizer.sv
// Receive side of the 64-bit packet stream: checks framing and sequence numbers, buffers
// payload words and replays them as one {ch_a, ch_b} sample pair per cycle.
module depacketizer
    import grex_pkt_pkg::*;
#(
    parameter int WORDS_PER_PKT = WORDS_PER_PKT_DEF,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic [63:0] rx_data,
    input  logic        rx_valid,
    input  logic        rx_eof,
    output logic [15:0] ch_a_out,
    output logic [15:0] ch_b_out,
    output logic        sample_valid,
    output logic        pkt_start,
    output logic        sync_out,
    output logic [63:0] seq_out,
    output logic [31:0] drop_count,
    output logic        len_err,
    output logic        overflow,
    output rx_state_e   rx_state_dbg
);

    // Handshakes: rx_valid qualifies rx_data for one cycle with no ready (the source cannot be
    // stalled), and sample_valid qualifies ch_*_out/pkt_start/sync_out for one cycle, also
    // without ready; both only take effect in cycles where ce=1.

    localparam int CW = $clog2(WORDS_PER_PKT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(WORDS_PER_PKT);

    rx_state_e          state;
    logic [CW-1:0]      word_cnt;
    logic [CW-1:0]      cnt_inc;
    logic [63:0]        exp_seq;
    logic               exp_valid;
    logic               push_q;
    logic [ENTRY_W-1:0] push_data_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic [ENTRY_W-1:0] rd_entry;
    logic               out_valid;
    logic               out_half;

    assign cnt_inc      = word_cnt + 1'b1;
    assign rx_state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RX_IDLE;
            word_cnt    <= '0;
            exp_seq     <= '0;
            exp_valid   <= 1'b0;
            seq_out     <= '0;
            drop_count  <= '0;
            len_err     <= 1'b0;
            overflow    <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else if (ce) begin
            len_err <= 1'b0;
            push_q  <= 1'b0;
            // The registered push lands in the FIFO this edge; a full FIFO drops it.
            if (push_q && fifo_full) begin
                overflow <= 1'b1;
            end
            case (state)
                RX_IDLE: begin
                    if (rx_valid) begin
                        seq_out  <= rx_data;
                        word_cnt <= '0;
                        state    <= RX_PAYLOAD;
                        if (exp_valid && (rx_data > exp_seq)) begin
                            drop_count <= drop_add(drop_count, rx_data - exp_seq);
                        end
                    end
                end
                RX_PAYLOAD: begin
                    if (rx_valid && (word_cnt == FULL_CNT)) begin
                        len_err   <= 1'b1;
                        exp_valid <= 1'b0;
                        state     <= rx_eof ? RX_IDLE : RX_DISCARD;
                    end else if (rx_valid) begin
                        word_cnt    <= cnt_inc;
                        push_q      <= 1'b1;
                        push_data_q <= {(word_cnt == '0) && (seq_out == 64'd0),
                                        (word_cnt == '0), rx_data};
                        if (rx_eof) begin
                            state <= RX_IDLE;
                            if (cnt_inc == FULL_CNT) begin
                                exp_seq   <= seq_out + 64'd1;
                                exp_valid <= 1'b1;
                            end else begin
                                len_err   <= 1'b1;
                                exp_valid <= 1'b0;
                            end
                        end
                    end else if (rx_eof) begin
                        state <= RX_IDLE;
                        if (word_cnt == FULL_CNT) begin
                            exp_seq   <= seq_out + 64'd1;
                            exp_valid <= 1'b1;
                        end else begin
                            len_err   <= 1'b1;
                            exp_valid <= 1'b0;
                        end
                    end
                end
                RX_DISCARD: begin
                    if (rx_eof) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    depack_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .wr_en   (push_q),
        .wr_data (push_data_q),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Fetch the next word during the second half so pairs stream without gaps.
    assign pop = !fifo_empty && (!out_valid || out_half);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_half  <= 1'b0;
        end else if (ce) begin
            if (pop) begin
                out_valid <= 1'b1;
                out_half  <= 1'b0;
            end else if (out_valid && !out_half) begin
                out_half <= 1'b1;
            end else begin
                out_valid <= 1'b0;
                out_half  <= 1'b0;
            end
        end
    end

    assign ch_a_out     = out_half ? rd_entry[A1_MSB:A1_LSB] : rd_entry[A0_MSB:A0_LSB];
    assign ch_b_out     = out_half ? rd_entry[B1_MSB:B1_LSB] : rd_entry[B0_MSB:B0_LSB];
    assign sample_valid = out_valid;
    assign pkt_start    = out_valid && !out_half && rd_entry[FIRST_BIT];
    assign sync_out     = out_valid && !out_half && rd_entry[SYNC_BIT];

endmodule

// File: tb/tb_depacketizer.sv
// Directed bench for depacketizer: stimulus pushes expected sample pairs into a queue and a
// negedge monitor pops and compares every emitted pair.
module tb_depacketizer;
    import grex_pkt_pkg::*;

    localparam int WPP   = 1024;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b1;
    logic [63:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_eof = 1'b0;
    logic [15:0] ch_a_out;
    logic [15:0] ch_b_out;
    logic        sample_valid;
    logic        pkt_start;
    logic        sync_out;
    logic [63:0] seq_out;
    logic [31:0] drop_count;
    logic        len_err;
    logic        overflow;
    rx_state_e   rx_state_dbg;

    depacketizer #(.WORDS_PER_PKT(WPP), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_eof       (rx_eof),
        .ch_a_out     (ch_a_out),
        .ch_b_out     (ch_b_out),
        .sample_valid (sample_valid),
        .pkt_start    (pkt_start),
        .sync_out     (sync_out),
        .seq_out      (seq_out),
        .drop_count   (drop_count),
        .len_err      (len_err),
        .overflow     (overflow),
        .rx_state_dbg (rx_state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [132:0] outs_vec;
    assign outs_vec = {ch_a_out, ch_b_out, sample_valid, pkt_start, sync_out,
                       seq_out, drop_count, len_err, overflow};

    // ---------------- scoreboard ----------------
    logic [33:0] exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          subset_mode = 1'b0;
    int          n_samp = 0;
    int          first_cyc = -1;
    int          last_cyc = 0;
    int          len_err_cnt = 0;
    int          t_first_word = 0;
    logic [33:0] mon_got;
    bit          mon_found;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst && ce && len_err) len_err_cnt++;
        if (rst && ce && sample_valid) begin
            mon_got = {pkt_start, sync_out, ch_a_out, ch_b_out};
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            n_samp++;
            if (subset_mode) begin
                mon_found = 1'b0;
                while (!mon_found && exp_q.size() > 0) begin
                    if (exp_q.pop_front() == mon_got) mon_found = 1'b1;
                end
                check("subset_order", 64'(mon_found), 64'd1);
            end else if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_sample: got %h, expected nothing (cycle %0d)", mon_got, cyc);
            end else begin
                check("sample", 64'(mon_got), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [63:0] mk_word(input int base, input int i);
        logic [15:0] v;
        v = 16'(base + i);
        return {v, v + 16'd1, v + 16'd2, v + 16'd3};
    endfunction

    task automatic push_exp(input logic [63:0] d, input bit first, input logic [63:0] hdr);
        exp_q.push_back({first, first && (hdr == 64'd0), d[63:48], d[47:32]});
        exp_q.push_back({2'b00, d[31:16], d[15:0]});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [63:0] d, input logic eof);
        rx_data  = d;
        rx_valid = 1'b1;
        rx_eof   = eof;
        idle(1);
        rx_valid = 1'b0;
        rx_eof   = 1'b0;
    endtask

    task automatic send_eof();
        rx_eof = 1'b1;
        idle(1);
        rx_eof = 1'b0;
    endtask

    task automatic send_pkt(input logic [63:0] hdr, input int nwords, input int n_exp,
                            input int base, input int gap, input bit eof_last);
        logic [63:0] d;
        send_word(hdr, 1'b0);
        idle(gap);
        for (int i = 0; i < nwords; i++) begin
            d = mk_word(base, i);
            if (i < n_exp) push_exp(d, i == 0, hdr);
            if (i == 0) t_first_word = cyc;
            send_word(d, eof_last && (i == nwords - 1));
            idle(gap);
        end
        if (!eof_last) send_eof();
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        #1;
        idle(4);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(3);
        exp_q.delete();
        rst = 1'b1;
        idle(2);
    endtask

    task automatic freeze_check();
        logic [132:0] snap;
        ce = 1'b0;
        @(negedge clk);
        snap = outs_vec;
        repeat (9) begin
            @(negedge clk);
            check("ce_freeze", 64'(outs_vec === snap), 64'd1);
        end
        @(posedge clk);
        #1;
        ce = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        idle(2);
        check("in_reset_outputs", 64'(|outs_vec), 64'd0);
        rst = 1'b1;
        idle(2);
        check("post_reset_outputs", 64'(|outs_vec), 64'd0);
        check("post_reset_state", 64'(rx_state_dbg), 64'(RX_IDLE));

        // 1: clean packet, header 0, paced one word every two cycles
        first_cyc = -1;
        send_pkt(64'd0, WPP, WPP, 0, 1, 1'b1);
        wait_drain("t1_drain");
        check("t1_latency", 64'(first_cyc - t_first_word), 64'd3);
        check("t1_seq", seq_out, 64'd0);
        check("t1_drop", 64'(drop_count), 64'd0);
        check("t1_len_err", 64'(len_err_cnt), 64'd0);
        check("t1_overflow", 64'(overflow), 64'd0);

        // 2: back-to-back headers 5 then 8 -> two packets missed
        do_reset();
        len_err_cnt = 0;
        send_pkt(64'd5, WPP, WPP, 'h2000, 1, 1'b1);
        send_pkt(64'd8, WPP, WPP, 'h3000, 1, 1'b1);
        wait_drain("t2_drain");
        check("t2_seq", seq_out, 64'd8);
        check("t2_drop", 64'(drop_count), 64'd2);
        check("t2_len_err", 64'(len_err_cnt), 64'd0);

        // 3: short packet, then header 4 with expected sequence invalid
        len_err_cnt = 0;
        send_pkt(64'd3, 1000, 1000, 'h4000, 1, 1'b1);
        wait_drain("t3a_drain");
        check("t3a_len_err", 64'(len_err_cnt), 64'd1);
        check("t3a_seq", seq_out, 64'd3);
        check("t3a_drop", 64'(drop_count), 64'd2);
        send_pkt(64'd4, WPP, WPP, 'h5000, 1, 1'b1);
        wait_drain("t3b_drain");
        check("t3b_len_err", 64'(len_err_cnt), 64'd1);
        check("t3b_seq", seq_out, 64'd4);
        check("t3b_drop", 64'(drop_count), 64'd2);

        // 3c: huge forward jump saturates drop_count; empty packet gives a len_err
        len_err_cnt = 0;
        send_word(64'h2_0000_0005, 1'b0);
        idle(1);
        send_eof();
        idle(4);
        check("t3c_drop_sat", 64'(drop_count), 64'hFFFF_FFFF);
        check("t3c_seq", seq_out, 64'h2_0000_0005);
        check("t3c_len_err", 64'(len_err_cnt), 64'd1);

        // 4: overlong packet, extra words discarded until a separate eof
        len_err_cnt = 0;
        send_pkt(64'd0, WPP + 3, WPP, 'h6000, 1, 1'b0);
        wait_drain("t4_drain");
        check("t4_len_err", 64'(len_err_cnt), 64'd1);
        check("t4_state", 64'(rx_state_dbg), 64'(RX_IDLE));
        check("t4_seq", seq_out, 64'd0);
        check("t4_drop", 64'(drop_count), 64'hFFFF_FFFF);

        // 5: unpaced burst into a small FIFO -> overflow, in-order subset, no output gaps
        do_reset();
        subset_mode = 1'b1;
        n_samp = 0;
        first_cyc = -1;
        len_err_cnt = 0;
        send_pkt(64'd10, WPP, WPP, 'h7000, 0, 1'b1);
        idle(80);
        check("t5_overflow", 64'(overflow), 64'd1);
        check("t5_gap_free", 64'(last_cyc - first_cyc + 1), 64'(n_samp));
        check("t5_subset_size", 64'((n_samp >= 32) && (n_samp < 2 * WPP)), 64'd1);
        idle(20);
        check("t5_overflow_sticky", 64'(overflow), 64'd1);
        check("t5_len_err", 64'(len_err_cnt), 64'd0);
        subset_mode = 1'b0;
        exp_q.delete();

        // 6: reset mid-packet, then clean packet 9 with a ce hold in the middle
        do_reset();
        check("t6_overflow_cleared", 64'(overflow), 64'd0);
        len_err_cnt = 0;
        send_word(64'd7, 1'b0);
        idle(1);
        for (int i = 0; i < 500; i++) begin
            push_exp(mk_word('h8000, i), i == 0, 64'd7);
            send_word(mk_word('h8000, i), 1'b0);
            idle(1);
        end
        rst = 1'b0;
        @(negedge clk);
        check("t6_reset_outputs", 64'(|outs_vec), 64'd0);
        check("t6_reset_state", 64'(rx_state_dbg), 64'(RX_IDLE));
        @(posedge clk);
        #1;
        exp_q.delete();
        idle(2);
        rst = 1'b1;
        idle(2);
        send_word(64'd9, 1'b0);
        idle(1);
        for (int i = 0; i < WPP; i++) begin
            if (i == 300) freeze_check();
            push_exp(mk_word('h9000, i), i == 0, 64'd9);
            send_word(mk_word('h9000, i), i == WPP - 1);
            idle(1);
        end
        wait_drain("t6_drain");
        check("t6_seq", seq_out, 64'd9);
        check("t6_drop", 64'(drop_count), 64'd0);
        check("t6_len_err", 64'(len_err_cnt), 64'd0);
        check("t6_overflow", 64'(overflow), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_500_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
